// File: rtl/instr_mem_loader_pkg.sv
// instr_loader_pkg: shared types and constants for the instruction memory loader.
//   ld_state_e        - loader FSM states
//   WORD_BYTES        - bytes per instruction word
//   DEFAULT_BASE_ADDR - default byte address of instruction word 0
package instr_loader_pkg;

  localparam int          WORD_BYTES        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream handshake plus instruction memory write bus.
//   s_data/s_valid/s_ready - byte stream (host -> loader)
//   we/wa/wd               - write strobe, byte address, data word (loader -> memory)
// Modports: master = stream source / memory side, slave = loader.
interface instr_mem_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;

  modport master (output s_data, s_valid, input s_ready, we, wa, wd);
  modport slave  (input s_data, s_valid, output s_ready, we, wa, wd);
endinterface

// File: rtl/loader_word_packer.sv
// loader_word_packer: assembles little-endian words from a byte stream.
//   clk, rst_n    - clock, synchronous active-low reset
//   clr           - synchronous clear of the partial word (new load)
//   byte_valid    - byte_in is consumed this cycle
//   byte_in       - stream byte
//   word_valid    - this cycle's byte completes a word (combinational)
//   word          - completed word, valid with word_valid
module loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] byte_cnt;
  // Only the first three bytes are stored; the fourth comes straight from
  // byte_in so the word is ready in the cycle it arrives. Bytes enter at the
  // top and shift down, leaving byte 0 in the low lane.
  logic [23:0]      sr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      byte_cnt <= '0;
      sr       <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      sr       <= {byte_in, sr[23:8]};
    end
  end

  assign word_valid = byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign word       = {byte_in, sr};

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writer side of the per-core instruction memory.
// Receives [N][4*N data bytes][checksum, optional] and writes N little-endian
// words starting at BASE_ADDR, holding the cores in reset until done.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - one-cycle load request (ignored while busy)
//   bus         - slave side of instr_mem_loader_if (stream in, write bus out)
//   busy        - load in progress (HDR/DATA/CHK)
//   done        - image loaded, sticky until next start
//   error       - load aborted, sticky until next start
//   cores_hold  - keep cores in reset (released only in DONE)
//   word_count  - words written in the current/last load
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cores_hold,
  output logic [7:0]          word_count
);

  ld_state_e   state, state_nxt;
  logic        xfer;
  logic        start_ok;
  logic        hdr_bad;
  logic        last_word;
  logic [7:0]  n_words;
  logic [7:0]  widx;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign xfer      = bus.s_valid && bus.s_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign hdr_bad   = (bus.s_data == 8'd0) || (bus.s_data > 8'(DEPTH));
  assign last_word = pk_valid && (widx == n_words - 8'd1);

  loader_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .byte_valid (xfer && state == DATA),
    .byte_in    (bus.s_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of the header and every data byte.
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (xfer && state == HDR) begin
      csum <= bus.s_data;
    end else if (xfer && state == DATA) begin
      csum <= csum ^ bus.s_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR;
      HDR:             if (xfer)  state_nxt = hdr_bad ? ERR : DATA;
`ifdef LOADER_CHECKSUM_EN
      DATA:            if (last_word) state_nxt = CHK;
      CHK:             if (xfer)  state_nxt = (csum == bus.s_data) ? DONE : ERR;
`else
      DATA:            if (last_word) state_nxt = DONE;
      CHK:             state_nxt = IDLE;
`endif
      default:         state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state. done rises on the same edge that raises the
  // final we, so it never precedes the last write.
  always_comb begin
    busy        = (state == HDR) || (state == DATA) || (state == CHK);
    bus.s_ready = busy;
    done        = (state == DONE);
    error       = (state == ERR);
    cores_hold  = (state != DONE);
  end

  // Write port and counters. we is a one-cycle pulse; wa/wd hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.we     <= 1'b0;
      bus.wa     <= '0;
      bus.wd     <= '0;
      word_count <= '0;
      n_words    <= '0;
      widx       <= '0;
    end else begin
      bus.we <= 1'b0;
      if (start_ok) word_count <= '0;
      if (xfer && state == HDR) begin
        n_words <= bus.s_data;
        widx    <= '0;
      end
      if (pk_valid) begin
        bus.we     <= 1'b1;
        bus.wa     <= BASE_ADDR + {22'd0, widx, 2'b00};
        bus.wd     <= pk_word;
        widx       <= widx + 8'd1;
        word_count <= word_count + 8'd1;
      end
    end
  end

endmodule
